handshake_rr_arbiter: RTL and testbench

- Shares one registered valid/ready output channel among NUM_REQ upstream requesters, using round-robin arbitration with burst locking.
- The output stage is a one-deep pipeline register: it loads whenever it is empty or the downstream consumer is ready.
- Sits in front of a single downstream pipeline stage so several producers can feed one consumer without combinational paths from ready_post_i to data.

---
 rtl/handshake_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ valid/ready producers onto one registered
// output channel, locking the grant for multi-beat bursts up to MAX_BEATS beats.
module handshake_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          valid_pre_i,
    input  logic [NUM_REQ*DATA_W-1:0]   data_i,
    input  logic [NUM_REQ-1:0]          last_i,
    output logic [NUM_REQ-1:0]          ready_pre_o,
    output logic                        valid_post_o,
    input  logic                        ready_post_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        last_o,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id_o
);

    localparam int IDW  = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_rr_ptr;
    logic [IDW-1:0]    w_rr_ptr_nxt;
    logic [IDW-1:0]    r_lock_id;
    logic [IDW-1:0]    w_lock_id_nxt;
    logic [CNTW-1:0]   r_beat_cnt;
    logic [CNTW-1:0]   w_beat_cnt_nxt;

    logic              r_vld_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic              r_last_p1;
    logic [IDW-1:0]    r_id_p1;

    logic [IDW-1:0]    w_grant;
    logic              w_grant_vld;
    logic [IDW-1:0]    w_scan_idx;
    logic              w_out_ready;
    logic              w_accept;
    logic              w_timeout;
    logic              w_eff_last;
    logic [DATA_W-1:0] w_data_sel;

    // Explicit wrap so non-power-of-two NUM_REQ never indexes past the last requester.
    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] idx);
        if (idx == IDW'(NUM_REQ - 1)) begin
            return '0;
        end
        return idx + IDW'(1);
    endfunction

    assign w_out_ready = ready_post_i | ~r_vld_p1;
    assign w_timeout   = (r_beat_cnt == CNTW'(MAX_BEATS - 1));

    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_scan_idx  = r_rr_ptr;
        if (r_state == ST_LOCKED) begin
            w_grant     = r_lock_id;
            w_grant_vld = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_grant_vld && valid_pre_i[w_scan_idx]) begin
                    w_grant     = w_scan_idx;
                    w_grant_vld = 1'b1;
                end
                w_scan_idx = next_idx(w_scan_idx);
            end
        end
    end

    always_comb begin
        ready_pre_o = '0;
        if (w_out_ready && w_grant_vld) begin
            ready_pre_o[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_data_sel = data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_accept   = w_out_ready & w_grant_vld & valid_pre_i[w_grant];
    assign w_eff_last = last_i[w_grant] | w_timeout;

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_lock_id_nxt  = r_lock_id;
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_accept) begin
            if (w_eff_last) begin
                w_state_nxt    = ST_IDLE;
                w_rr_ptr_nxt   = next_idx(w_grant);
                w_beat_cnt_nxt = '0;
            end else begin
                w_state_nxt    = ST_LOCKED;
                w_lock_id_nxt  = w_grant;
                w_beat_cnt_nxt = r_beat_cnt + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_id  <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_lock_id  <= w_lock_id_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Stage p1: output register; holds everything while downstream stalls a valid beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_last_p1 <= 1'b0;
            r_id_p1   <= '0;
        end else if (w_out_ready) begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_data_p1 <= w_data_sel;
                r_last_p1 <= w_eff_last;
                r_id_p1   <= w_grant;
            end
        end
    end

    assign valid_post_o = r_vld_p1;
    assign data_o       = r_data_p1;
    assign last_o       = r_last_p1;
    assign grant_id_o   = r_id_p1;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Directed bench for handshake_rr_arbiter: stimulus pushes expected output beats into
// a queue, and a negedge monitor pops and compares every transferred output beat.
module tb_handshake_rr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BEATS = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        valid_pre_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        last_i;
    logic [NUM_REQ-1:0]        ready_pre_o;
    logic                      valid_post_o;
    logic                      ready_post_i;
    logic [DATA_W-1:0]         data_o;
    logic                      last_o;
    logic [1:0]                grant_id_o;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] id;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    handshake_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BEATS(MAX_BEATS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_pre_i (valid_pre_i),
        .data_i      (data_i),
        .last_i      (last_i),
        .ready_pre_o (ready_pre_o),
        .valid_post_o(valid_post_o),
        .ready_post_i(ready_post_i),
        .data_o      (data_o),
        .last_o      (last_o),
        .grant_id_o  (grant_id_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        valid_pre_i[i]      = v;
        data_i[i*DATA_W +: DATA_W] = d;
        last_i[i]           = l;
    endtask

    task automatic push(input logic [7:0] d, input logic l, input logic [1:0] id);
        beat_t b;
        b.data = d;
        b.last = l;
        b.id   = id;
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (valid_post_o && ready_post_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data 0x%0h id %0d, expected no beat", data_o, grant_id_o);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(data_o), 32'(e.data));
                chk("beat_last", 32'(last_o), 32'(e.last));
                chk("beat_id", 32'(grant_id_o), 32'(e.id));
            end
        end
    end

    initial begin
        reset        = 1'b1;
        valid_pre_i  = '0;
        data_i       = '0;
        last_i       = '0;
        ready_post_i = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // Reset state with all requesters idle.
        chk("rst_valid", 32'(valid_post_o), 32'h0);
        chk("rst_ready", 32'(ready_pre_o), 32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_id", 32'(grant_id_o), 32'h0);
        chk("rst_last", 32'(last_o), 32'h0);

        // Round robin over single-beat transfers: 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_ready", 32'(ready_pre_o), 32'(4'b0001 << (k % 4)));
            push(8'(8'h10 + (k % 4)), 1'b1, 2'(k % 4));
            step();
        end
        valid_pre_i = '0;
        step();

        // Burst lock on req1 (rr_ptr=1) with a valid gap mid-burst.
        set_req(0, 1'b1, 8'hA0, 1'b1);
        set_req(2, 1'b1, 8'hC0, 1'b1);
        set_req(1, 1'b1, 8'hB1, 1'b0);
        #1;
        chk("lock_first", 32'(ready_pre_o), 32'h2);
        push(8'hB1, 1'b0, 2'd1);
        step();
        set_req(1, 1'b0, 8'hB1, 1'b0);
        #1;
        chk("lock_gap", 32'(ready_pre_o), 32'h2);
        step();
        set_req(1, 1'b1, 8'hB2, 1'b0);
        #1;
        chk("lock_second", 32'(ready_pre_o), 32'h2);
        push(8'hB2, 1'b0, 2'd1);
        step();
        set_req(1, 1'b1, 8'hB3, 1'b1);
        push(8'hB3, 1'b1, 2'd1);
        step();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("after_lock", 32'(ready_pre_o), 32'h4);
        push(8'hC0, 1'b1, 2'd2);
        step();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("wrap_to_0", 32'(ready_pre_o), 32'h1);
        push(8'hA0, 1'b1, 2'd0);
        step();
        set_req(0, 1'b0, 8'h00, 1'b0);
        step();

        // Backpressure: rr_ptr=1, req3 wins, then 3 stalled cycles.
        set_req(0, 1'b1, 8'h40, 1'b1);
        set_req(3, 1'b1, 8'h43, 1'b1);
        #1;
        chk("bp_grant", 32'(ready_pre_o), 32'h8);
        push(8'h43, 1'b1, 2'd3);
        step();
        set_req(3, 1'b0, 8'h00, 1'b0);
        ready_post_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 32'(ready_pre_o), 32'h0);
            chk("bp_valid", 32'(valid_post_o), 32'h1);
            chk("bp_data", 32'(data_o), 32'h43);
            chk("bp_last", 32'(last_o), 32'h1);
            chk("bp_id", 32'(grant_id_o), 32'h3);
            step();
        end
        ready_post_i = 1'b1;
        #1;
        chk("bp_release", 32'(ready_pre_o), 32'h1);
        push(8'h40, 1'b1, 2'd0);
        step();
        set_req(0, 1'b0, 8'h00, 1'b0);
        step();

        // Timeout: req3 streams without last; 4th beat is forced last (MAX_BEATS=4).
        set_req(0, 1'b1, 8'h50, 1'b1);
        for (int b = 0; b < 4; b++) begin
            set_req(3, 1'b1, 8'(8'h31 + b), 1'b0);
            #1;
            chk("to_grant", 32'(ready_pre_o), 32'h8);
            push(8'(8'h31 + b), (b == 3), 2'd3);
            step();
        end
        set_req(3, 1'b1, 8'h35, 1'b0);
        #1;
        chk("to_release", 32'(ready_pre_o), 32'h1);
        push(8'h50, 1'b1, 2'd0);
        step();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("to_regrant", 32'(ready_pre_o), 32'h8);
        push(8'h35, 1'b0, 2'd3);
        step();
        set_req(3, 1'b1, 8'h36, 1'b1);
        push(8'h36, 1'b1, 2'd3);
        step();
        set_req(3, 1'b0, 8'h00, 1'b0);
        step();

        // Reset mid-burst: req2 locked after 2 beats (rr_ptr=0).
        set_req(2, 1'b1, 8'h21, 1'b0);
        #1;
        chk("mid_grant", 32'(ready_pre_o), 32'h4);
        push(8'h21, 1'b0, 2'd2);
        step();
        set_req(2, 1'b1, 8'h22, 1'b0);
        push(8'h22, 1'b0, 2'd2);
        step();
        reset = 1'b1;
        set_req(1, 1'b1, 8'h11, 1'b1);
        set_req(2, 1'b1, 8'h23, 1'b0);
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(valid_post_o), 32'h0);
        chk("mid_rst_data", 32'(data_o), 32'h0);
        chk("mid_rst_id", 32'(grant_id_o), 32'h0);
        chk("mid_rst_ready", 32'(ready_pre_o), 32'h2);
        push(8'h11, 1'b1, 2'd1);
        step();
        valid_pre_i = '0;

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats still outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
